ps2_mouse_packet_rx: RTL
========================

// Module: ps2_mouse_packet_rx
// PURPOSE
//   Host-side PS/2 mouse receiver. Samples the raw ps2_clk/ps2_data lines and
//   deserialises 11-bit device frames. Assembles each standard 3-byte movement
//   packet into signed X/Y increments and button states.
//   Drives the data_ready / x_increment / y_increment / button inputs of
//   ps2_dataprogramme, which turns them into cursor position.
// PARAMETERS
//   FILTER_LEN      8        consecutive equal sys_clk samples needed to accept a ps2_clk level change
//   TIMEOUT_CYCLES  200000   idle sys_clk cycles (2 ms @100 MHz) after which a partial frame is dropped
// PORTS
//   sys_clk        in   1  system clock, 100 MHz
//   reset_n        in   1  asynchronous, active-low reset
//   ps2_clk        in   1  PS/2 clock line (device-driven, idle high)
//   ps2_data       in   1  PS/2 data line
//   data_ready     out  1  one-cycle pulse: new packet on the outputs below
//   x_increment    out  9  signed X movement {sign, byte1}
//   y_increment    out  9  signed Y movement {sign, byte2}
//   left_button    out  1  packet byte0[0]
//   right_button   out  1  packet byte0[1]
//   middle_button  out  1  packet byte0[2]
//   frame_error    out  1  one-cycle pulse: bad parity or bad stop bit
// BEHAVIOUR
//   Reset: all outputs 0, filtered clk = 1, bit count 0, timeout counter 0, FSM WAIT_B0.
//     Reset is asynchronous and may arrive mid-frame or mid-packet; all partial state is discarded.
//   Input conditioning:
//     - ps2_clk and ps2_data each pass through a 2-FF synchroniser.
//     - Filtered clk toggles only after FILTER_LEN equal samples.
//     - A 1->0 transition of the filtered clk is the falling-edge strobe (fe).
//   Frame reception, on each fe:
//     - Shift in the synchronised data bit.
//     - Frame = start(0), D0..D7 LSB first, odd parity, stop(1).
//     - bit0 == 1: not a start bit; ignore it, bit count stays 0.
//     - After 11 bits with parity and stop correct: byte_valid pulses next cycle.
//     - Parity wrong or stop == 0: frame_error pulses instead; the byte is dropped
//       and the packet FSM returns to WAIT_B0.
//   Timeout:
//     - Counter runs while bit count != 0 and clears on each fe.
//     - At TIMEOUT_CYCLES: drop the partial frame, FSM returns to WAIT_B0.
//     - No frame_error is raised for a timeout.
//     - fe and expiry in the same cycle: fe wins.
//   Packet FSM:
//     WAIT_B0 -> WAIT_B1  on byte with bit3 == 1. Latch buttons[2:0], xs = b[4],
//                         ys = b[5], xo = b[6], yo = b[7].
//                         A byte with bit3 == 0 is discarded and the FSM stays in WAIT_B0.
//     WAIT_B1 -> WAIT_B2  latch X byte.
//     WAIT_B2 -> WAIT_B0  latch Y byte, request output update.
//   Output update: registered, 1 cycle after byte_valid of byte2.
//     - data_ready = 1 for exactly one cycle.
//     - x_increment = {xs, X}; y_increment = {ys, Y}.
//     - Overflow saturation: xo = 1 gives 9'h0FF if xs = 0, else 9'h100. Y uses yo/ys identically.
//     - Buttons update in the same cycle.
//     - All outputs hold until the next packet; only data_ready returns to 0.
//   Latency: data_ready rises 2 sys_clk cycles after the fe of byte2's stop bit.
//     That fe itself trails the pin edge by 2 + FILTER_LEN cycles.
//   ps2_clk low at reset release: the filter produces an fe after FILTER_LEN cycles.
//     The resulting garbage frame is rejected by the start, parity or timeout rules.
//   Receive only: this block never drives the PS/2 lines.
// STRUCTURE
//   Package ps2_mouse_pkg:
//     - FRAME_BITS = 11.
//     - Byte0 bit-index constants (BTN_L = 0, BTN_R = 1, BTN_M = 2, ALIGN = 3,
//       XSIGN = 4, YSIGN = 5, XOVF = 6, YOVF = 7).
//     - Packet FSM state encoding (WAIT_B0, WAIT_B1, WAIT_B2).
//     - Saturation constants SAT_POS = 9'h0FF, SAT_NEG = 9'h100.
//   Sub-module ps2_frame_rx:
//     - Contains synchronisers, filter, fe detect, shift register, parity check and timeout.
//     - Outputs byte_valid, byte_data[7:0], frame_error, frame_abort.
//   Top level: packet FSM, saturation logic and output registers.
// TESTING
//   PS/2 device model drives 11-bit frames at 10 kHz, changing data while ps2_clk is high.
//   1. Hold reset_n low mid-frame -> all outputs 0. After release, a fresh packet decodes normally.
//   2. Bytes 0x09, 0x38, 0x30 -> one data_ready pulse; x = 9'h038, y = 9'h030, left = 1, right = 0, middle = 0.
//   3. Bytes 0x39, 0xD0, 0xC8 -> x = 9'h1D0, y = 9'h1C8, left = 1.
//   4. Bytes 0x4A, 0x10, 0x05 (X overflow) -> x = 9'h0FF, y = 9'h005, right = 1.
//   5. Byte1 sent with wrong parity -> frame_error pulse, no data_ready.
//      Next packet 0x08, 0x01, 0x02 -> x = 1, y = 2.
//   6. Lone byte 0x00, then 5 bits and a gap > TIMEOUT_CYCLES, then 0x08, 0x03, 0x04
//      -> exactly one data_ready, with x = 3, y = 4.

Source files
------------

// File: rtl/ps2_mouse_pkg.sv
// Shared constants, FSM encoding and the saturation helper
// for the PS/2 mouse packet receiver.
`timescale 1ns/1ps
package ps2_mouse_pkg;

   localparam int FRAME_BITS = 11;

   localparam int BTN_L = 0;
   localparam int BTN_R = 1;
   localparam int BTN_M = 2;
   localparam int ALIGN = 3;
   localparam int XSIGN = 4;
   localparam int YSIGN = 5;
   localparam int XOVF  = 6;
   localparam int YOVF  = 7;

   localparam logic [8:0] SAT_POS = 9'h0FF;
   localparam logic [8:0] SAT_NEG = 9'h100;

   typedef enum logic [1:0] {
      WAIT_B0 = 2'd0,
      WAIT_B1 = 2'd1,
      WAIT_B2 = 2'd2
   } pkt_state_t;

   function automatic logic [8:0] sat_val(
      input logic       ovf,
      input logic       sgn,
      input logic [7:0] mag
   );
      if (ovf) return sgn ? SAT_NEG : SAT_POS;
      return {sgn, mag};
   endfunction

endpackage

// File: rtl/ps2_mouse_packet_rx_frame_rx.sv
// Line conditioning and 11-bit frame deserialiser: sync, clock
// glitch filter, falling-edge strobe, parity/stop check, timeout.
`timescale 1ns/1ps
module ps2_frame_rx
   import ps2_mouse_pkg::*;
#(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 200000
) (
   input  logic       sys_clk,
   input  logic       reset_n,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       byte_valid,
   output logic [7:0] byte_data,
   output logic       frame_error,
   output logic       frame_abort
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [FW-1:0] F_LAST = FW'(FILTER_LEN - 1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

   logic          clk_s1, clk_s2;
   logic          dat_s1, dat_s2;
   logic          filt, filt_q;
   logic [FW-1:0] fcnt;
   logic          fe;
   logic [3:0]    bit_cnt;
   logic [9:0]    shreg;
   logic [TW-1:0] to_cnt;
   logic          frame_ok;

   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         clk_s1 <= 1'b1;
         clk_s2 <= 1'b1;
         dat_s1 <= 1'b1;
         dat_s2 <= 1'b1;
      end else begin
         clk_s1 <= ps2_clk;
         clk_s2 <= clk_s1;
         dat_s1 <= ps2_data;
         dat_s2 <= dat_s1;
      end
   end

   // Level change accepted only after FILTER_LEN consecutive differing samples
   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         filt   <= 1'b1;
         filt_q <= 1'b1;
         fcnt   <= '0;
      end else begin
         filt_q <= filt;
         if (clk_s2 == filt) begin
            fcnt <= '0;
         end else if (fcnt == F_LAST) begin
            filt <= clk_s2;
            fcnt <= '0;
         end else begin
            fcnt <= fcnt + 1'b1;
         end
      end
   end

   assign fe = filt_q & ~filt;

   // shreg holds start..parity with start at bit 0; dat_s2 is the stop bit
   assign frame_ok = dat_s2 & (^shreg[9:1]);

   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         bit_cnt     <= '0;
         shreg       <= '0;
         to_cnt      <= '0;
         byte_data   <= '0;
         byte_valid  <= 1'b0;
         frame_error <= 1'b0;
         frame_abort <= 1'b0;
      end else begin
         byte_valid  <= 1'b0;
         frame_error <= 1'b0;
         frame_abort <= 1'b0;
         if (fe) begin
            to_cnt <= '0;
            if (bit_cnt == 4'd0 && dat_s2) begin
               bit_cnt <= '0;
            end else if (bit_cnt == LAST_BIT) begin
               bit_cnt <= '0;
               if (frame_ok) begin
                  byte_valid <= 1'b1;
                  byte_data  <= shreg[8:1];
               end else begin
                  frame_error <= 1'b1;
               end
            end else begin
               shreg   <= {dat_s2, shreg[9:1]};
               bit_cnt <= bit_cnt + 1'b1;
            end
         end else if (bit_cnt != 4'd0) begin
            if (to_cnt == T_LAST) begin
               bit_cnt     <= '0;
               to_cnt      <= '0;
               frame_abort <= 1'b1;
            end else begin
               to_cnt <= to_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/ps2_mouse_packet_rx.sv
// PS/2 mouse receiver top: 3-byte packet FSM, overflow
// saturation and registered movement/button outputs.
`timescale 1ns/1ps
module ps2_mouse_packet_rx
   import ps2_mouse_pkg::*;
#(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 200000
) (
   input  logic       sys_clk,
   input  logic       reset_n,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       data_ready,
   output logic [8:0] x_increment,
   output logic [8:0] y_increment,
   output logic       left_button,
   output logic       right_button,
   output logic       middle_button,
   output logic       frame_error
);

   logic       byte_valid;
   logic [7:0] byte_data;
   logic       frame_abort;

   pkt_state_t state, nxt;
   logic       ld_hdr, ld_x, upd;
   logic [7:0] hdr;
   logic [7:0] xb;

   ps2_frame_rx #(
      .FILTER_LEN    (FILTER_LEN),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_frame (
      .sys_clk    (sys_clk),
      .reset_n    (reset_n),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .frame_error(frame_error),
      .frame_abort(frame_abort)
   );

   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) state <= WAIT_B0;
      else          state <= nxt;
   end

   always_comb begin
      nxt    = state;
      ld_hdr = 1'b0;
      ld_x   = 1'b0;
      upd    = 1'b0;
      if (frame_error || frame_abort) begin
         nxt = WAIT_B0;
      end else if (byte_valid) begin
         unique case (state)
            WAIT_B0: begin
               if (byte_data[ALIGN]) begin
                  nxt    = WAIT_B1;
                  ld_hdr = 1'b1;
               end
            end
            WAIT_B1: begin
               nxt  = WAIT_B2;
               ld_x = 1'b1;
            end
            WAIT_B2: begin
               nxt = WAIT_B0;
               upd = 1'b1;
            end
            default: nxt = WAIT_B0;
         endcase
      end
   end

   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         hdr <= '0;
         xb  <= '0;
      end else begin
         if (ld_hdr) hdr <= byte_data;
         if (ld_x)   xb  <= byte_data;
      end
   end

   // The Y byte is consumed straight off byte_data in the update cycle
   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         data_ready    <= 1'b0;
         x_increment   <= '0;
         y_increment   <= '0;
         left_button   <= 1'b0;
         right_button  <= 1'b0;
         middle_button <= 1'b0;
      end else begin
         data_ready <= upd;
         if (upd) begin
            x_increment   <= sat_val(hdr[XOVF], hdr[XSIGN], xb);
            y_increment   <= sat_val(hdr[YOVF], hdr[YSIGN], byte_data);
            left_button   <= hdr[BTN_L];
            right_button  <= hdr[BTN_R];
            middle_button <= hdr[BTN_M];
         end
      end
   end

endmodule
